// File: rtl/sysctrl_gen.sv
// MCU system-control endpoint: decodes framed byte commands into LED, colour,
// button, config-register and interrupt operations, with a registered reply byte.
module sysctrl_gen #(
    parameter logic [7:0]                 CORE_ID     = 8'h03,
    parameter int                         NUM_CFG     = 16,
    parameter int                         CFG_W       = 8,
    parameter logic [NUM_CFG*CFG_W-1:0]   CFG_DEFAULT = '0,
    parameter int                         INT_N       = 8,
    parameter int                         LED_N       = 2,
    parameter int                         BTN_N       = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       data_in_strobe,
    input  logic                       data_in_start,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    output logic                       int_out_n,
    input  logic [INT_N-1:0]           int_in,
    output logic [INT_N-1:0]           int_ack,
    input  logic [BTN_N-1:0]           buttons,
    output logic [LED_N-1:0]           leds,
    output logic [23:0]                color,
    output logic [NUM_CFG*CFG_W-1:0]   cfg_flat,
    output logic                       cfg_wr_stb,
    output logic [7:0]                 cfg_wr_id
);

    localparam int         CFG_BYTES = (CFG_W + 7) / 8;
    localparam logic [3:0] LAST_K    = 4'(CFG_BYTES + 1);
    localparam logic [3:0] K_MAX     = 4'd15;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_LEDS   = 8'h01;
    localparam logic [7:0] CMD_COLOR  = 8'h02;
    localparam logic [7:0] CMD_BTN    = 8'h03;
    localparam logic [7:0] CMD_CFG_WR = 8'h04;
    localparam logic [7:0] CMD_INT    = 8'h05;
    localparam logic [7:0] CMD_CFG_RD = 8'h06;
    localparam logic [7:0] CMD_MASK   = 8'h07;

    // Frame byte index k: 0 = idle, 1..15 = payload position (saturating).
    logic [3:0]         state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         id_q, id_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [7:0]         dout_d;
    logic [LED_N-1:0]   leds_d;
    logic [23:0]        color_d;
    logic [INT_N-1:0]   mask_q, mask_d;
    logic [INT_N-1:0]   ack_d;
    logic [INT_N-1:1]   pending_q;
    logic [INT_N-1:1]   int_prev_q;
    logic               coldboot_q;
    logic               commit;
    logic [7:0]         wr_id_d;
    logic [7:0]         rd_idx;
    logic [15:0]        rd_val;
    logic [CFG_W-1:0]   cfg_q [NUM_CFG];
    logic               unused_int0;

    assign unused_int0 = int_in[0];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_flat
        assign cfg_flat[g*CFG_W +: CFG_W] = cfg_q[g];
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        id_d     = id_q;
        shadow_d = shadow_q;
        dout_d   = data_out;
        leds_d   = leds;
        color_d  = color;
        mask_d   = mask_q;
        ack_d    = '0;
        commit   = 1'b0;
        wr_id_d  = cfg_wr_id;

        // Readback index comes straight from the bus on the first payload byte.
        rd_idx = (state_q == 4'd1) ? data_in : id_q;
        rd_val = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_idx == 8'(i)) rd_val = 16'(cfg_q[i]);
        end

        if (data_in_strobe) begin
            if (data_in_start) begin
                cmd_d    = data_in;
                state_d  = 4'd1;
                shadow_d = '0;
            end else if (state_q != 4'd0) begin
                if (state_q != K_MAX) state_d = state_q + 4'd1;
                case (cmd_q)
                    CMD_STATUS: begin
                        case (state_q)
                            4'd1:    dout_d = 8'h5C;
                            4'd2:    dout_d = 8'h42;
                            4'd3:    dout_d = CORE_ID;
                            4'd4:    dout_d = 8'(NUM_CFG);
                            default: ;
                        endcase
                    end
                    CMD_LEDS: begin
                        if (state_q == 4'd1) leds_d = data_in[LED_N-1:0];
                    end
                    CMD_COLOR: begin
                        case (state_q)
                            4'd1:    color_d[15:8]  = rev8(data_in);
                            4'd2:    color_d[7:0]   = rev8(data_in);
                            4'd3:    color_d[23:16] = rev8(data_in);
                            default: ;
                        endcase
                    end
                    CMD_BTN: begin
                        dout_d = 8'(buttons);
                    end
                    CMD_CFG_WR: begin
                        if (state_q == 4'd1) begin
                            id_d = data_in;
                        end else if (state_q <= LAST_K) begin
                            if (state_q == 4'd2) shadow_d[7:0]  = data_in;
                            else                 shadow_d[15:8] = data_in;
                            if (state_q == LAST_K && id_q < 8'(NUM_CFG)) begin
                                commit  = 1'b1;
                                wr_id_d = id_q;
                            end
                        end
                    end
                    CMD_INT: begin
                        dout_d = 8'({pending_q, coldboot_q});
                        if (state_q == 4'd1) ack_d = data_in[INT_N-1:0];
                    end
                    CMD_CFG_RD: begin
                        if (state_q == 4'd1) id_d = data_in;
                        // rd_val is zero-padded above CFG_W, so bytes past the register read 0.
                        if (state_q == 4'd1)      dout_d = rd_val[7:0];
                        else if (state_q == 4'd2) dout_d = rd_val[15:8];
                        else                      dout_d = 8'h00;
                    end
                    CMD_MASK: begin
                        if (state_q == 4'd1) mask_d = data_in[INT_N-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= '0;
            cmd_q      <= '0;
            id_q       <= '0;
            shadow_q   <= '0;
            data_out   <= '0;
            leds       <= '0;
            color      <= '0;
            mask_q     <= '1;
            int_ack    <= '0;
            cfg_wr_stb <= 1'b0;
            cfg_wr_id  <= '0;
            pending_q  <= '0;
            int_prev_q <= '0;
            coldboot_q <= 1'b1;
            int_out_n  <= 1'b1;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_DEFAULT[i*CFG_W +: CFG_W];
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            id_q       <= id_d;
            shadow_q   <= shadow_d;
            data_out   <= dout_d;
            leds       <= leds_d;
            color      <= color_d;
            mask_q     <= mask_d;
            int_ack    <= ack_d;
            cfg_wr_stb <= commit;
            cfg_wr_id  <= wr_id_d;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (commit && id_q == 8'(i)) cfg_q[i] <= shadow_d[CFG_W-1:0];
            end
            // A fresh edge in the same cycle as the ack clear keeps the bit set.
            int_prev_q <= int_in[INT_N-1:1];
            pending_q  <= (pending_q & ~int_ack[INT_N-1:1]) | (int_in[INT_N-1:1] & ~int_prev_q);
            coldboot_q <= coldboot_q & ~int_ack[0];
            int_out_n  <= ~((|(pending_q & mask_q[INT_N-1:1])) | (coldboot_q & mask_q[0]));
        end
    end

endmodule

// File: tb/tb_sysctrl_gen.sv
// Bench for sysctrl_gen: byte-vector table, hand-written interrupt/reset
// sequences and random frames checked against a byte-level command model.
`timescale 1ns/1ps
module tb_sysctrl_gen;

    localparam int NUM_CFG = 16;
    localparam int CFG_W   = 12;
    localparam int INT_N   = 8;
    localparam int LED_N   = 2;
    localparam int BTN_N   = 2;
    localparam int FW      = NUM_CFG * CFG_W;

    function automatic logic [FW-1:0] mk_def();
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CFG; i++) v[i*CFG_W +: CFG_W] = 12'h100 + 12'(i);
        return v;
    endfunction

    localparam logic [FW-1:0] CFG_DEF = mk_def();

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             data_in_strobe = 1'b0;
    logic             data_in_start = 1'b0;
    logic [7:0]       data_in = 8'h00;
    logic [7:0]       data_out;
    logic             int_out_n;
    logic [INT_N-1:0] int_in = '0;
    logic [INT_N-1:0] int_ack;
    logic [BTN_N-1:0] buttons = '0;
    logic [LED_N-1:0] leds;
    logic [23:0]      color;
    logic [FW-1:0]    cfg_flat;
    logic             cfg_wr_stb;
    logic [7:0]       cfg_wr_id;

    sysctrl_gen #(
        .CORE_ID(8'h03), .NUM_CFG(NUM_CFG), .CFG_W(CFG_W), .CFG_DEFAULT(CFG_DEF),
        .INT_N(INT_N), .LED_N(LED_N), .BTN_N(BTN_N)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
        .data_out(data_out), .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .cfg_flat(cfg_flat),
        .cfg_wr_stb(cfg_wr_stb), .cfg_wr_id(cfg_wr_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_k;
    logic [7:0] m_cmd, m_id, m_dout, m_mask, m_pending, m_wr_id, m_ack;
    logic [15:0] m_val;
    logic [11:0] m_cfg [NUM_CFG];
    logic [1:0] m_leds;
    logic [23:0] m_color;
    bit         m_cold, m_stb;
    logic [7:0] rise_on_ack = 8'h00;

    function automatic logic [7:0] rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
        return r;
    endfunction

    function automatic logic [FW-1:0] exp_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NUM_CFG; i++) f[i*CFG_W +: CFG_W] = m_cfg[i];
        return f;
    endfunction

    function automatic logic exp_int_n();
        return !((|(m_pending & m_mask & 8'hFE)) || (m_cold && m_mask[0]));
    endfunction

    task automatic model_reset();
        m_k = 0; m_cmd = 0; m_id = 0; m_val = 0; m_dout = 0; m_leds = 0; m_color = 0;
        m_mask = 8'hFF; m_pending = 0; m_cold = 1; m_wr_id = 0; m_stb = 0; m_ack = 0;
        for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = CFG_DEF[i*CFG_W +: CFG_W];
    endtask

    task automatic model_byte(input bit start, input logic [7:0] b);
        int k;
        logic [7:0] idx;
        logic [15:0] w;
        m_stb = 0;
        m_ack = 0;
        if (start) begin
            m_cmd = b; m_k = 1; m_val = 0;
        end else if (m_k != 0) begin
            k = m_k;
            if (m_k < 15) m_k++;
            case (m_cmd)
                8'h00: case (k)
                    1: m_dout = 8'h5C;
                    2: m_dout = 8'h42;
                    3: m_dout = 8'h03;
                    4: m_dout = 8'(NUM_CFG);
                    default: ;
                endcase
                8'h01: if (k == 1) m_leds = b[1:0];
                8'h02: case (k)
                    1: m_color[15:8]  = rev(b);
                    2: m_color[7:0]   = rev(b);
                    3: m_color[23:16] = rev(b);
                    default: ;
                endcase
                8'h03: m_dout = {6'b0, buttons};
                8'h04: begin
                    if (k == 1) m_id = b;
                    else if (k == 2) m_val[7:0] = b;
                    else if (k == 3) begin
                        m_val[15:8] = b;
                        if (m_id < NUM_CFG) begin
                            m_cfg[m_id[3:0]] = m_val[11:0];
                            m_stb = 1;
                            m_wr_id = m_id;
                        end
                    end
                end
                8'h05: begin
                    m_dout = m_pending | {7'b0, m_cold};
                    if (k == 1) m_ack = b;
                end
                8'h06: begin
                    idx = (k == 1) ? b : m_id;
                    if (k == 1) m_id = b;
                    if (idx < NUM_CFG && k <= 2) begin
                        w = {4'b0, m_cfg[idx[3:0]]};
                        m_dout = (k == 1) ? w[7:0] : w[15:8];
                    end else m_dout = 8'h00;
                end
                8'h07: if (k == 1) m_mask = b;
                default: ;
            endcase
        end
    endtask

    // Drive one byte and check every output against the model over the next three cycles.
    task automatic send_byte(input bit start, input logic [7:0] b);
        @(negedge clk);
        data_in_strobe = 1'b1; data_in_start = start; data_in = b;
        model_byte(start, b);
        @(negedge clk);
        data_in_strobe = 1'b0; data_in_start = 1'b0;
        if (rise_on_ack != 0 && m_ack != 0) int_in = int_in | rise_on_ack;
        chk("data_out", data_out, m_dout);
        chk("leds", leds, m_leds);
        chk("color", color, m_color);
        chk("cfg_flat", cfg_flat, exp_flat());
        chk("cfg_wr_stb", cfg_wr_stb, m_stb);
        chk("cfg_wr_id", cfg_wr_id, m_wr_id);
        chk("int_ack", int_ack, m_ack);
        m_pending = (m_pending & ~m_ack & 8'hFE) | ((m_ack != 0) ? rise_on_ack : 8'h00);
        if (m_ack[0]) m_cold = 0;
        @(negedge clk);
        if (m_stb) chk("cfg_wr_stb_pulse", cfg_wr_stb, 1'b0);
        if (m_ack != 0) chk("int_ack_pulse", int_ack, 8'h00);
        @(negedge clk);
        chk("int_out_n", int_out_n, exp_int_n());
    endtask

    task automatic set_int(input logic [7:0] v);
        @(negedge clk);
        m_pending = m_pending | (v & ~int_in & 8'hFE);
        int_in = v;
        repeat (3) @(negedge clk);
        chk("int_out_n_edge", int_out_n, exp_int_n());
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data_out"}, data_out, 8'h00);
        chk({tag, "_leds"}, leds, 2'b00);
        chk({tag, "_color"}, color, 24'h0);
        chk({tag, "_int_ack"}, int_ack, 8'h00);
        chk({tag, "_cfg_wr_stb"}, cfg_wr_stb, 1'b0);
        chk({tag, "_cfg_wr_id"}, cfg_wr_id, 8'h00);
        chk({tag, "_cfg_flat"}, cfg_flat, CFG_DEF);
    endtask

    typedef struct {
        bit         start;
        logic [7:0] data;
        bit         chk_en;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h11, 1'b1, 8'h5C};
        vecs[2]  = '{1'b0, 8'h22, 1'b1, 8'h42};
        vecs[3]  = '{1'b0, 8'h33, 1'b1, 8'h03};
        vecs[4]  = '{1'b0, 8'h44, 1'b1, 8'h10};
        vecs[5]  = '{1'b0, 8'h55, 1'b1, 8'h10};
        vecs[6]  = '{1'b1, 8'h06, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 8'h02, 1'b1, 8'h02};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h01};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 8'h04, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 8'h05, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 8'h34, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 8'h0A, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 8'h06, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 8'h05, 1'b1, 8'h34};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 8'h0A};
        vecs[17] = '{1'b1, 8'h06, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 8'h10, 1'b1, 8'h00};
        vecs[19] = '{1'b1, 8'h03, 1'b0, 8'h00};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 8'h02};
        vecs[21] = '{1'b1, 8'h09, 1'b0, 8'h00};
        vecs[22] = '{1'b0, 8'h12, 1'b1, 8'h02};
        vecs[23] = '{1'b0, 8'h00, 1'b0, 8'h00};

        // Clock/reset
        model_reset();
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("coldboot_int_out_n", int_out_n, 1'b0);

        // Table-driven vectors
        buttons = 2'b10;
        for (int i = 0; i < 24; i++) begin
            send_byte(vecs[i].start, vecs[i].data);
            if (vecs[i].chk_en) chk($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp);
        end
        chk("cfg5_value", cfg_flat[5*CFG_W +: CFG_W], 12'hA34);
        chk("cfg5_wr_id", cfg_wr_id, 8'h05);

        // Out-of-range id and truncated frame leave config untouched
        send_byte(1, 8'h04); send_byte(0, 8'h10); send_byte(0, 8'hAA); send_byte(0, 8'hBB);
        send_byte(1, 8'h04); send_byte(0, 8'h03); send_byte(0, 8'h55);
        send_byte(1, 8'h00); send_byte(0, 8'h00);
        chk("cfg3_untouched", cfg_flat[3*CFG_W +: CFG_W], 12'h103);
        chk("cfg16_no_wr_id", cfg_wr_id, 8'h05);

        // Interrupt edge, readback and ack
        set_int(8'h08);
        send_byte(1, 8'h05); send_byte(0, 8'h00);
        chk("int_status_09", data_out, 8'h09);
        send_byte(1, 8'h05); send_byte(0, 8'h09);
        chk("int_cleared_n", int_out_n, 1'b1);
        send_byte(1, 8'h05); send_byte(0, 8'h00);
        chk("int_status_00", data_out, 8'h00);

        // Masked source still reported
        send_byte(1, 8'h07); send_byte(0, 8'hF7);
        set_int(8'h00);
        set_int(8'h08);
        chk("masked_int_out_n", int_out_n, 1'b1);
        send_byte(1, 8'h05); send_byte(0, 8'h00);
        chk("masked_status_08", data_out, 8'h08);

        // New edge coincident with the ack clear keeps the bit
        set_int(8'h00);
        rise_on_ack = 8'h08;
        send_byte(1, 8'h05); send_byte(0, 8'h08);
        rise_on_ack = 8'h00;
        send_byte(1, 8'h05); send_byte(0, 8'h00);
        chk("ack_race_status", data_out, 8'h08);

        // Colour bit reversal
        send_byte(1, 8'h02); send_byte(0, 8'h80); send_byte(0, 8'h01); send_byte(0, 8'hFF);
        chk("color_ff0180", color, 24'hFF0180);

        // Reset mid-frame
        set_int(8'h00);
        send_byte(1, 8'h01); send_byte(0, 8'h03);
        send_byte(1, 8'h04); send_byte(0, 8'h07); send_byte(0, 8'h11);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midframe");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised frames against the model
        for (int n = 0; n < 250; n++) begin
            bit st;
            int c;
            logic [7:0] b;
            buttons = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 99) < 25);
            if (st) begin
                c = $urandom_range(0, 9);
                b = (c == 9) ? 8'($urandom_range(8, 255)) : 8'(c);
            end else if (m_k == 1 && (m_cmd == 8'h04 || m_cmd == 8'h06)) begin
                b = 8'($urandom_range(0, 19));
            end else begin
                b = 8'($urandom);
            end
            send_byte(st, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
